// File: rtl/des_pkg.sv
// des_pkg: shared constants and types for the DES key schedule blocks.
//
// Bit-index convention: index i of any vector carries DES bit i+1.
// DES tables are 1-based and count from the MSB of the printed hex string.
// So DES bit n of a 64-bit key lives at key_in[n-1]. C occupies cd[27:0] and
// D occupies cd[55:28], which means DES bit p of C||D is cd[p-1].
//
// Contents:
//   PC1     : 56-entry permuted choice 1 (C bits 1..28, then D bits 1..28)
//   PC2     : 48-entry permuted choice 2 over C||D
//   ROT_DEC : right-rotate amounts for the decrypt walk. This is the encrypt
//             left-shift schedule for rounds 16 down to 2.
//   sched_state_e : schedule controller states
//   ror1    : rotate a 28-bit half right by one position
package des_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } sched_state_e;

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] ROT_DEC [15] = '{
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Right rotate by one in index terms: new[i+1] = old[i], new[0] = old[27].
    function automatic logic [27:0] ror1(input logic [27:0] v);
        return {v[26:0], v[27]};
    endfunction

endpackage

// File: rtl/des_key_schedule_dec_pc2.sv
// des_pc2: fixed PC-2 permutation, 56-bit C||D in, 48-bit subkey out.
// This block is purely combinational. It is shared with the encrypt schedule.
//
// Ports:
//   cd_in  [55:0] : C in [27:0], D in [55:28] (index i = DES bit i+1)
//   k_out  [47:0] : subkey (index i = DES bit i+1)
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd_in,
    output logic [47:0] k_out
);

    generate
        for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
            assign k_out[gi] = cd_in[PC2[gi] - 1];
        end
    endgenerate

endmodule

// File: rtl/des_key_schedule_dec.sv
// des_key_schedule_dec: iterative DES key schedule for decryption.
// The block loads a key, applies PC-1, and hands out subkeys K16 down to K1,
// one per valid/ack handshake. C and D rotate right between subkeys.
//
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   load, key_in    : key load request and 64-bit key (index i = DES bit i+1)
//   busy            : high while a schedule is being emitted
//   subkey          : current 48-bit subkey, forced to 0 when not valid
//   subkey_valid    : subkey is presented
//   subkey_ack      : consumer accepts the presented subkey
//   round_num       : DES round of the presented subkey minus 1 (15..0)
//   done            : one-cycle pulse after K1 is accepted
//   key_parity_err  : a loaded key byte had even parity (sticky until next load)
module des_key_schedule_dec
    import des_pkg::*;
#(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] key_in,
    output logic        busy,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ack,
    output logic [3:0]  round_num,
    output logic        done,
    output logic        key_parity_err
);

    sched_state_e state_q, state_d;
    logic [27:0]  c_q, c_d;
    logic [27:0]  d_q, d_d;
    logic [3:0]   count_q, count_d;
    logic         done_q, done_d;
    logic         perr_q, perr_d;

    logic [55:0]  pc1_key;
    logic [7:0]   byte_even;
    logic [47:0]  pc2_out;
    logic         emit;

    // PC-1 is used only at load, so it stays inline as plain wiring.
    generate
        for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_key[gi] = key_in[PC1[gi] - 1];
        end
        // Each DES byte should have odd parity. An XNOR-reduce of 1 flags a bad byte.
        for (genvar gi = 0; gi < 8; gi++) begin : g_parity
            assign byte_even[gi] = ~^key_in[8*gi+7 -: 8];
        end
    endgenerate

    // The first subkey emitted is K16, which uses C0/D0 directly.
    // That works because the full 28 encrypt rotations return C16 = C0.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        count_d = count_q;
        done_d  = 1'b0;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    c_d     = pc1_key[27:0];
                    d_d     = pc1_key[55:28];
                    count_d = 4'd0;
                    perr_d  = PARITY_CHECK ? (|byte_even) : 1'b0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                // A load request here is ignored, including one that arrives
                // in the same cycle as the final ack.
                if (subkey_ack) begin
                    if (count_q == 4'd15) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        if (ROT_DEC[count_q] == 2'd2) begin
                            c_d = ror1(ror1(c_q));
                            d_d = ror1(ror1(d_q));
                        end else begin
                            c_d = ror1(c_q);
                            d_d = ror1(d_q);
                        end
                        count_d = count_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            count_q <= count_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
        end
    end

    des_pc2 u_pc2 (
        .cd_in ( 56'({d_q, c_q})),
        .k_out (pc2_out)
    );

    assign emit           = (state_q == EMIT);
    assign busy           = emit;
    assign subkey_valid   = emit;
    assign subkey         = emit ? pc2_out : 48'd0;
    assign round_num      = emit ? (4'd15 - count_q) : 4'd0;
    assign done           = done_q;
    assign key_parity_err = perr_q;

endmodule

// File: tb/tb_des_key_schedule_dec.sv
module tb_des_key_schedule_dec;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [63:0] key_in;
    logic        busy;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ack;
    logic [3:0]  round_num;
    logic        done;
    logic        key_parity_err;

    always #5 clk = ~clk;

    des_key_schedule_dec #(.PARITY_CHECK(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .key_in         (key_in),
        .busy           (busy),
        .subkey         (subkey),
        .subkey_valid   (subkey_valid),
        .subkey_ack     (subkey_ack),
        .round_num      (round_num),
        .done           (done),
        .key_parity_err (key_parity_err)
    );

    typedef struct packed {
        logic [3:0]  rnd;
        logic [47:0] sk;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference tables in standard DES numbering (1-based, counted from the MSB).
    int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,
                       11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,
                       61,53,45,37,29,21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int shl_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // Encrypt-direction subkeys K1..K16 as 48-bit DES-order values (bit 1 = MSB).
    logic [47:0] ks_des [1:16];

    localparam logic [63:0] STD_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] STD_K16 = 48'hCB3D8B0E17F5;
    localparam logic [47:0] STD_K1  = 48'h1B02EFFC7072;

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63-i];
        return r;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = v[47-i];
        return r;
    endfunction

    // Any byte with an even count of ones counts as a parity error.
    function automatic logic parity_bad(input logic [63:0] k);
        logic bad;
        logic [63:0] t;
        bad = 1'b0;
        t = k;
        for (int b = 0; b < 8; b++) begin
            if (($countones(t[7:0]) % 2) == 0) bad = 1'b1;
            t = t >> 8;
        end
        return bad;
    endfunction

    // Textbook encrypt schedule with left rotations.
    task automatic build_model(input logic [63:0] key_des);
        logic [28:1] c;
        logic [28:1] d;
        int p;
        for (int j = 1; j <= 28; j++) begin
            c[j] = key_des[64 - pc1_t[j-1]];
            d[j] = key_des[64 - pc1_t[j+27]];
        end
        for (int r = 1; r <= 16; r++) begin
            for (int s = 0; s < shl_t[r-1]; s++) begin
                c = {c[1], c[28:2]};
                d = {d[1], d[28:2]};
            end
            for (int k = 1; k <= 48; k++) begin
                p = pc2_t[k-1];
                ks_des[r][48-k] = (p <= 28) ? c[p] : d[p-28];
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ack_mode: 0 = always ack, 1 = 1,0,0,1 pattern, 2 = random.
    // busy_rnd >= 0 drives load with key 0 while round_num == busy_rnd.
    // abort_rnd >= 0 pulses rst when round_num == abort_rnd.
    // load_final drives load in the same cycle as the final ack.
    // chk_std compares the DUT's K16 and K1 against the published constants.
    task automatic run(input string name, input logic [63:0] key_des, input int ack_mode,
                       input int busy_rnd, input int abort_rnd, input bit load_final,
                       input bit chk_std);
        int          cyc;
        int          accepts;
        bit          fin;
        bit          prev_hold;
        bit          ack_now;
        bit          seen_done;
        logic [47:0] prev_sk;
        logic [3:0]  prev_rn;
        logic        exp_perr;
        exp_t        e;
        cyc = 0; accepts = 0; fin = 0; prev_hold = 0; seen_done = 0;
        prev_sk = '0; prev_rn = '0;
        exp_perr = parity_bad(key_des);
        build_model(key_des);
        sb_q.delete();
        for (int r = 16; r >= 1; r--) begin
            e.rnd = 4'(r - 1);
            e.sk  = rev48(ks_des[r]);
            sb_q.push_back(e);
        end
        @(negedge clk);
        key_in = rev64(key_des);
        load = 1'b1;
        subkey_ack = 1'b0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            load = 1'b0;
            if (cyc == 1) begin
                check({name, ":first_valid"}, 64'(subkey_valid), 64'd1);
                check({name, ":parity_err"}, 64'(key_parity_err), 64'(exp_perr));
                if (chk_std) begin
                    check({name, ":k16_const"}, 64'(subkey), 64'(rev48(STD_K16)));
                    check({name, ":k16_round"}, 64'(round_num), 64'd15);
                end
            end
            if (done) begin
                check({name, ":done_busy"}, 64'(busy), 64'd0);
                check({name, ":done_valid"}, 64'(subkey_valid), 64'd0);
                check({name, ":done_subkey"}, 64'(subkey), 64'd0);
                check({name, ":accepts"}, 64'(accepts), 64'd16);
                check({name, ":sb_left"}, 64'(sb_q.size()), 64'd0);
                check({name, ":perr_hold"}, 64'(key_parity_err), 64'(exp_perr));
                if (ack_mode == 0) check({name, ":done_cycle"}, 64'(cyc), 64'd17);
                fin = 1;
                subkey_ack = 1'b0;
                @(negedge clk);
                check({name, ":done_pulse"}, 64'(done), 64'd0);
                check({name, ":idle_valid"}, 64'(subkey_valid), 64'd0);
            end else if (subkey_valid) begin
                check({name, ":busy"}, 64'(busy), 64'd1);
                if (prev_hold) begin
                    check({name, ":hold_subkey"}, 64'(subkey), 64'(prev_sk));
                    check({name, ":hold_round"}, 64'(round_num), 64'(prev_rn));
                end
                if (abort_rnd >= 0 && round_num == 4'(abort_rnd)) begin
                    rst = 1'b1;
                    subkey_ack = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    check({name, ":abort_busy"}, 64'(busy), 64'd0);
                    check({name, ":abort_valid"}, 64'(subkey_valid), 64'd0);
                    check({name, ":abort_subkey"}, 64'(subkey), 64'd0);
                    check({name, ":abort_round"}, 64'(round_num), 64'd0);
                    check({name, ":abort_perr"}, 64'(key_parity_err), 64'd0);
                    for (int i = 0; i < 20; i++) begin
                        seen_done |= done;
                        @(negedge clk);
                    end
                    check({name, ":abort_no_done"}, 64'(seen_done), 64'd0);
                    sb_q.delete();
                    fin = 1;
                end else begin
                    case (ack_mode)
                        0:       ack_now = 1'b1;
                        1:       ack_now = ((cyc % 4) == 1) || ((cyc % 4) == 0);
                        default: ack_now = 1'($urandom_range(0, 1));
                    endcase
                    subkey_ack = ack_now;
                    if (busy_rnd >= 0 && round_num == 4'(busy_rnd)) begin
                        load = 1'b1;
                        key_in = 64'd0;
                    end
                    if (load_final && round_num == 4'd0 && ack_now) begin
                        load = 1'b1;
                        key_in = ~key_in;
                    end
                    if (ack_now) begin
                        if (sb_q.size() == 0) begin
                            check({name, ":extra_accept"}, 64'(accepts), 64'd16);
                        end else begin
                            e = sb_q.pop_front();
                            check({name, ":round"}, 64'(round_num), 64'(e.rnd));
                            check({name, ":subkey"}, 64'(subkey), 64'(e.sk));
                            if (chk_std && e.rnd == 4'd0)
                                check({name, ":k1_const"}, 64'(subkey), 64'(rev48(STD_K1)));
                        end
                        accepts++;
                    end
                    prev_hold = !ack_now;
                    prev_sk = subkey;
                    prev_rn = round_num;
                end
            end
        end
        check({name, ":finished"}, 64'(fin), 64'd1);
        subkey_ack = 1'b0;
        load = 1'b0;
        $display("run %s key=%h mode=%0d accepts=%0d cycles=%0d", name, key_des, ack_mode, accepts, cyc);
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        key_in = '0;
        subkey_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset:busy", 64'(busy), 64'd0);
        check("reset:valid", 64'(subkey_valid), 64'd0);
        check("reset:subkey", 64'(subkey), 64'd0);
        check("reset:round", 64'(round_num), 64'd0);
        check("reset:done", 64'(done), 64'd0);
        check("reset:perr", 64'(key_parity_err), 64'd0);

        run("std", STD_KEY, 0, -1, -1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            run("rand", {$urandom(), $urandom()}, 0, -1, -1, 1'b0, 1'b0);
        run("bp_pat", STD_KEY, 1, -1, -1, 1'b0, 1'b1);
        run("bp_rand", {$urandom(), $urandom()}, 2, -1, -1, 1'b0, 1'b0);
        run("load_busy", STD_KEY, 0, 10, -1, 1'b0, 1'b1);
        run("abort", {$urandom(), $urandom()}, 1, -1, 7, 1'b0, 1'b0);
        run("fresh", STD_KEY, 0, -1, -1, 1'b0, 1'b1);
        run("par_bad", STD_KEY ^ 64'h8000_0000_0000_0000, 0, -1, -1, 1'b0, 1'b0);
        run("par_good", STD_KEY, 2, -1, -1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/des_key_schedule_dec.md
Name: des_key_schedule_dec

Overview:
Iterative DES key schedule for the decryption direction. It loads a 64-bit key, applies PC-1, and emits the 16 48-bit round subkeys in reverse order (K16 first, K1 last), one per accepted handshake. It feeds the round engine when that engine runs in decrypt mode. It uses right rotations, the mirror of the left-rotating encrypt schedule.

Parameters:
PARITY_CHECK, 0, 1 = check odd parity on each key byte at load and report it on key_parity_err; 0 = key_parity_err tied to 0.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
load  input  1  key load request; accepted only in IDLE
key_in  input  64  DES key; index i = DES bit i+1 (index 0 = DES bit 1)
busy  output  1  high from load acceptance until the last subkey is accepted
subkey  output  48  current subkey; index i = DES bit i+1
subkey_valid  output  1  subkey is presented
subkey_ack  input  1  consumer accepts subkey when high with subkey_valid
round_num  output  4  DES round of the presented subkey, minus 1 (15 = K16 ... 0 = K1)
done  output  1  one-cycle pulse after K1 is accepted
key_parity_err  output  1  sticky until next load; set if any key byte has even parity

Behaviour:
- Reset: state IDLE; C, D, count cleared; busy=0, subkey_valid=0, subkey=0, round_num=0, done=0, key_parity_err=0. Reset mid-sequence aborts immediately, and no done pulse is produced.
- State IDLE: when load=1, C/D <= PC-1(key_in) (28+28 bits, DES bit numbering), count <= 0, parity check is latched, and the block goes to EMIT. load while busy is ignored, and registers are unaffected.
- State EMIT: subkey_valid=1 and subkey = PC-2(C,D), registered (C/D) then combinational PC-2. The first valid appears 1 cycle after load acceptance. round_num = 15 - count.
- Rotation on valid&&ack with count<15:
  - Rotate C and D right by R[count], where R = 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - R is the encrypt shift schedule for rounds 16 down to 2.
  - Right rotate by 1 in index terms: new[i+1]=old[i], new[0]=old[27]. Rotate by 2 applies this twice in one cycle.
  - count increments.
- Last subkey: on valid&&ack with count==15, go to IDLE. subkey_valid drops, done=1 for that next cycle, and busy=0 in the same cycle.
- No ack: subkey, round_num and C/D hold.
- Continuous ack: 16 subkeys on 16 consecutive cycles; total 17 cycles from load to done.
- The first subkey uses C0,D0 directly, because the 28 total rotations return C16=C0.
- subkey is forced to 0 whenever subkey_valid=0.
- A load arriving in the same cycle as the final ack is ignored (the block is still in EMIT). load is accepted from the following cycle.
- PARITY_CHECK=1: key_parity_err <= OR over 8 bytes of (XNOR-reduce of the byte). Each byte is key_in[8k+7:8k], with the parity bit at DES bit 8k+8. The flag does not block the schedule.

Decomposition:
- Shared package des_pkg holds:
  - PC1 (56 entries), PC2 (48 entries) and the decrypt rotate schedule R (15 entries) as constant arrays
  - a state enum {IDLE, EMIT}
  - the DES bit-index convention note
- Sub-module des_pc2: combinational 56→48 permutation, in the same style as the existing fixed-permutation blocks, reused by the encrypt schedule.
- PC-1 is inline (used once).

Test Plan:
- Standard key: key 133457799BBCDFF1, hex in DES order (bit 1 = MSB), load then hold ack=1 → first valid 1 cycle later; round_num 15 with subkey CB3D8B0E17F5 (DES order); last subkey round_num 0 = 1B02EFFC7072; done pulses on cycle 17; busy low with done.
- Full reversal: same key → all 16 subkeys equal the encrypt schedule's K1..K16 in reverse, checked against a reference model for 3 random keys.
- Backpressure: ack toggling 1,0,0,1 pseudo-randomly → subkey/round_num stable while ack=0; exactly 16 accepts before done; no skipped or duplicated rounds.
- Load while busy: load with key 0 at round_num 10 → ignored; the remaining subkeys still match the original key.
- Reset mid-run: assert rst at round_num 7 → next cycle all outputs 0 and no done pulse; a fresh load then runs normally.
- Parity (PARITY_CHECK=1): key 133457799BBCDFF1 → key_parity_err=0; flip bit 0 → 1 and the schedule is still produced; next good-key load clears it.
